// File: rtl/grf_wb_pkg.sv
// Shared definitions for the GRF write-back queue: register/word widths and entry layout.
// GRF_WB_TRACE_EN adds a pc field to each entry for the simulation trace.
package grf_wb_pkg;

  localparam int REG_AW  = 5;
  localparam int WORD_DW = 32;
  localparam int PC_W    = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0]  addr;
    logic [WORD_DW-1:0] data;
`ifdef GRF_WB_TRACE_EN
    logic [PC_W-1:0]    pc;
`endif
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_lookup.sv
// Bypass lookup for one GRF read port: the youngest pending entry whose address matches wins.
// Entries are scanned from head (oldest) to tail, so the last match found is the youngest.
module grf_wb_lookup
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WORD_DW,
  parameter int AW    = REG_AW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0]               head,
  input  logic [DEPTH-1:0]            ent_valid,
  input  logic [DEPTH-1:0][AW-1:0]    ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]    ent_data,
  input  logic [AW-1:0]               lk_addr,
  output logic                        lk_hit,
  output logic [DW-1:0]               lk_data
);

  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[head + PW'(i)] && (ent_addr[head + PW'(i)] == lk_addr) &&
          (lk_addr != '0)) begin
        lk_hit  = 1'b1;
        lk_data = ent_data[head + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// In-order write-back queue feeding the GRF write port, with two bypass lookup ports.
// Define GRF_WB_TRACE_EN to store the producer pc per entry and print each GRF write.
module grf_wb_queue
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WORD_DW,
  parameter int AW    = REG_AW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_pc,
  output logic          WE,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD,
  input  logic [AW-1:0] lk_addr1,
  input  logic [AW-1:0] lk_addr2,
  output logic          lk_hit1,
  output logic          lk_hit2,
  output logic [DW-1:0] lk_data1,
  output logic [DW-1:0] lk_data2,
  output logic [CW-1:0] count
);

  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic                     push, pop;

  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no
  // latch is inferred; state registers below use non-blocking '<=' only.
  always_comb begin
    in_ready = (count_q != CW'(DEPTH));
    push     = in_valid && in_ready && (in_addr != '0);
    pop      = (count_q != '0);

    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;

    // Pop first: a push can only land on the popped slot when the queue was full,
    // which in_ready already forbids.
    if (pop) begin
      head_d          = head_q + PW'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PW'(1);
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = in_addr;
      data_d[tail_q]  = in_data;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: entry payload is left unreset; valid_q alone decides whether a slot is observed.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    WE    = (count_q != '0);
    A3    = WE ? addr_q[head_q] : '0;
    WD    = WE ? data_q[head_q] : '0;
    count = count_q;
  end

  grf_wb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW)) u_lookup1 (
    .head      (head_q),
    .ent_valid (valid_q),
    .ent_addr  (addr_q),
    .ent_data  (data_q),
    .lk_addr   (lk_addr1),
    .lk_hit    (lk_hit1),
    .lk_data   (lk_data1)
  );

  grf_wb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW)) u_lookup2 (
    .head      (head_q),
    .ent_valid (valid_q),
    .ent_addr  (addr_q),
    .ent_data  (data_q),
    .lk_addr   (lk_addr2),
    .lk_hit    (lk_hit2),
    .lk_data   (lk_data2)
  );

`ifdef GRF_WB_TRACE_EN
  logic [DEPTH-1:0][31:0] pc_q;

  always_ff @(posedge clk) begin
    if (push) pc_q[tail_q] <= in_pc;
  end

  always_ff @(posedge clk) begin
    if (reset && WE) $display("@%h: $%d <= %h", pc_q[head_q], A3, WD);
  end
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Self-checking bench for grf_wb_queue: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_grf_wb_queue;
  import grf_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [4:0]  lk_addr1, lk_addr2;
  logic        lk_hit1, lk_hit2;
  logic [31:0] lk_data1, lk_data2;
  logic [2:0]  count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_pc    (in_pc),
    .WE       (WE),
    .A3       (A3),
    .WD       (WD),
    .lk_addr1 (lk_addr1),
    .lk_addr2 (lk_addr2),
    .lk_hit1  (lk_hit1),
    .lk_hit2  (lk_hit2),
    .lk_data1 (lk_data1),
    .lk_data2 (lk_data2),
    .count    (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] l1, input logic [4:0] l2);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_pc    = 32'h0040_3000 + {27'd0, a};
    lk_addr1 = l1;
    lk_addr2 = l2;
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: pending entries, oldest at index 0.
  wb_entry_t model_q[$];

  task automatic model_lookup(input logic [4:0] la, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
    if (la != 5'd0) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].addr == la) begin
          hit  = 1'b1;
          data = model_q[i].data;
          break;
        end
      end
    end
  endtask

  initial begin
    logic        exp_hit;
    logic [31:0] exp_data;
    logic        model_ready;
    logic        rst_now;
    wb_entry_t   e;

    // Reset held with a valid request offered: nothing may be enqueued.
    reset = 1'b0;
    drive(1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd0);
    step();
    step();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("reset_we", 32'(WE), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_hit1", 32'(lk_hit1), 32'd0);
    check("reset_a3", 32'(A3), 32'd0);
    check("reset_wd", WD, 32'd0);

    // Each row: inputs applied this cycle, outputs expected this cycle (before its edge).
    vecs[0] = '{1'b1, 5'd8, 32'h1234, 5'd8, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 3'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,    5'd8, 5'd8, 1'b1, 5'd8, 32'h1234, 1'b1, 32'h1234, 1'b1, 32'h1234, 3'd1};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFF, 5'd8, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 3'd0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 3'd0};
    vecs[4] = '{1'b1, 5'd3, 32'hA,    5'd3, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 3'd0};
    vecs[5] = '{1'b1, 5'd3, 32'hB,    5'd3, 5'd0, 1'b1, 5'd3, 32'hA,    1'b1, 32'hA,    1'b0, 32'h0, 3'd1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,    5'd3, 5'd0, 1'b1, 5'd3, 32'hB,    1'b1, 32'hB,    1'b0, 32'h0, 3'd1};
    vecs[7] = '{1'b0, 5'd0, 32'h0,    5'd3, 5'd3, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 3'd0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].l1, vecs[i].l2);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d_we", i), 32'(WE), 32'(vecs[i].we));
      check($sformatf("vec%0d_a3", i), 32'(A3), 32'(vecs[i].a3));
      check($sformatf("vec%0d_wd", i), WD, vecs[i].wd);
      check($sformatf("vec%0d_hit1", i), 32'(lk_hit1), 32'(vecs[i].h1));
      check($sformatf("vec%0d_data1", i), lk_data1, vecs[i].d1);
      check($sformatf("vec%0d_hit2", i), 32'(lk_hit2), 32'(vecs[i].h2));
      check($sformatf("vec%0d_data2", i), lk_data2, vecs[i].d2);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      step();
    end

    // Back-to-back pushes of $1..$5: the drain keeps pace, so count stays <= 1.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k + 1), 32'h100 + 32'(k), 5'(k), 5'd0);
      #1;
      check($sformatf("fill%0d_ready", k), 32'(in_ready), 32'd1);
      check($sformatf("fill%0d_count_le1", k), 32'(count <= 3'd1), 32'd1);
      if (k > 0) begin
        check($sformatf("fill%0d_a3", k), 32'(A3), 32'(k));
        check($sformatf("fill%0d_wd", k), WD, 32'h100 + 32'(k - 1));
      end
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    #1;
    check("fill_last_a3", 32'(A3), 32'd5);
    check("fill_last_hit", 32'(lk_hit1), 32'd1);
    step();
    check("fill_drained_we", 32'(WE), 32'd0);

    // Reset mid-operation: pending $6 is dropped, $7 offered under reset is discarded.
    drive(1'b1, 5'd6, 32'h66, 5'd7, 5'd6);
    step();
    drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd6);
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd6);
    #1;
    check("midrst_we", 32'(WE), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_hit1", 32'(lk_hit1), 32'd0);
    check("midrst_hit2", 32'(lk_hit2), 32'd0);
    step();

    // Randomized run against the reference model.
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      rst_now = ($urandom_range(0, 39) == 0);
      reset   = !rst_now;
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 6)), $urandom(),
            5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
      #1;
      model_ready = (model_q.size() != DEPTH);
      check("rnd_ready", 32'(in_ready), 32'(model_ready));
      check("rnd_count", 32'(count), 32'(model_q.size()));
      check("rnd_we", 32'(WE), 32'(model_q.size() != 0));
      check("rnd_a3", 32'(A3), (model_q.size() != 0) ? 32'(model_q[0].addr) : 32'd0);
      check("rnd_wd", WD, (model_q.size() != 0) ? model_q[0].data : 32'd0);
      model_lookup(lk_addr1, exp_hit, exp_data);
      check("rnd_hit1", 32'(lk_hit1), 32'(exp_hit));
      check("rnd_data1", lk_data1, exp_data);
      model_lookup(lk_addr2, exp_hit, exp_data);
      check("rnd_hit2", 32'(lk_hit2), 32'(exp_hit));
      check("rnd_data2", lk_data2, exp_data);

      if (rst_now) begin
        model_q.delete();
      end else begin
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (in_valid && model_ready && in_addr != 5'd0) begin
          e = '0;
          e.addr = in_addr;
          e.data = in_data;
          model_q.push_back(e);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
